// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RISC-V immediate decoder (I/S/B/J/U/Z/none) with sign extension to XLEN,
// followed by STAGES (1 or 2) stall/flush-controlled register stages.
// Optional feature macro: IMM_ZICSR_EN (selector 101 decodes the CSR uimm instead of
// being reported as an illegal format).
module imm_gen_pipe #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned STAGES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  input  logic [31:0]     instr_i,
  input  logic [2:0]      imm_src_i,
  input  logic            stall_i,
  input  logic            flush_i,
  output logic            valid_o,
  output logic [XLEN-1:0] imm_o,
  output logic            fmt_err_o
);

  logic [XLEN-1:0] dec_imm;
  logic            dec_err;

  // Opcode bits never contribute to an immediate.
  logic unused_opcode;
  assign unused_opcode = ^instr_i[6:0];

  // Decode the selected immediate format; signed size casts perform the sign extension.
  always_comb begin
    dec_imm = '0;
    dec_err = 1'b0;
    case (imm_src_i)
      3'b000: dec_imm = XLEN'($signed(instr_i[31:20]));
      3'b001: dec_imm = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
      3'b010: dec_imm = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                        instr_i[11:8], 1'b0}));
      3'b011: dec_imm = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                        instr_i[30:21], 1'b0}));
      3'b100: dec_imm = XLEN'($signed({instr_i[31:12], 12'b0}));
`ifdef IMM_ZICSR_EN
      3'b101: dec_imm = XLEN'(instr_i[19:15]);
`else
      3'b101: dec_err = 1'b1;
`endif
      3'b110: dec_err = 1'b0;
      default: dec_err = 1'b1;
    endcase
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic            in_valid;
    logic [XLEN-1:0] in_imm;
    logic            in_err;
    logic            valid_d, valid_q;
    logic [XLEN-1:0] imm_d, imm_q;
    logic            err_d, err_q;

    if (g == 0) begin : g_head
      assign in_valid = valid_i;
      assign in_imm   = dec_imm;
      assign in_err   = dec_err;
    end else begin : g_tail
      assign in_valid = g_stage[g-1].valid_q;
      assign in_imm   = g_stage[g-1].imm_q;
      assign in_err   = g_stage[g-1].err_q;
    end

    // Flush kills valid regardless of stall; payload only loads behind a valid entry.
    always_comb begin
      valid_d = valid_q;
      imm_d   = imm_q;
      err_d   = err_q;
      if (flush_i) begin
        valid_d = 1'b0;
      end else if (!stall_i) begin
        valid_d = in_valid;
        if (in_valid) begin
          imm_d = in_imm;
          err_d = in_err;
        end
      end
    end

    // Stage register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        imm_q   <= '0;
        err_q   <= 1'b0;
      end else begin
        valid_q <= valid_d;
        imm_q   <= imm_d;
        err_q   <= err_d;
      end
    end
  end

  assign valid_o   = g_stage[STAGES-1].valid_q;
  assign imm_o     = g_stage[STAGES-1].imm_q;
  assign fmt_err_o = g_stage[STAGES-1].err_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit/1-stage and a 64-bit/2-stage instance share stimulus;
// a per-instance scoreboard queue is filled on capture and drained as outputs advance.
module tb_imm_gen_pipe;

  typedef struct packed {
    logic [63:0] imm;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        valid_i;
  logic [31:0] instr_i;
  logic [2:0]  imm_src_i;
  logic        stall_i;
  logic        flush_i;

  logic        valid_a, err_a;
  logic [31:0] imm_a;
  logic        valid_b, err_b;
  logic [63:0] imm_b;

  int   errors = 0;
  int   checks = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  logic adv = 1'b0;

  imm_gen_pipe #(.XLEN(32), .STAGES(1)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_i   (valid_i),
    .instr_i   (instr_i),
    .imm_src_i (imm_src_i),
    .stall_i   (stall_i),
    .flush_i   (flush_i),
    .valid_o   (valid_a),
    .imm_o     (imm_a),
    .fmt_err_o (err_a)
  );

  imm_gen_pipe #(.XLEN(64), .STAGES(2)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_i   (valid_i),
    .instr_i   (instr_i),
    .imm_src_i (imm_src_i),
    .stall_i   (stall_i),
    .flush_i   (flush_i),
    .valid_o   (valid_b),
    .imm_o     (imm_b),
    .fmt_err_o (err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode, written from the format bit layouts at 64 bits.
  function automatic exp_t model(input logic [31:0] i, input logic [2:0] src);
    exp_t e;
    e.imm = '0;
    e.err = 1'b0;
    case (src)
      3'd0: e.imm = {{52{i[31]}}, i[31:20]};
      3'd1: e.imm = {{52{i[31]}}, i[31:25], i[11:7]};
      3'd2: e.imm = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd3: e.imm = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      3'd4: e.imm = {{32{i[31]}}, i[31:12], 12'b0};
`ifdef IMM_ZICSR_EN
      3'd5: e.imm = {59'b0, i[19:15]};
`else
      3'd5: e.err = 1'b1;
`endif
      3'd6: e.err = 1'b0;
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  // Outputs move only after a non-stalled edge; pop once per such edge.
  always @(posedge clk) adv <= !stall_i || flush_i;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && adv) begin
      if (valid_a) begin
        checks++;
        if (q_a.size() == 0) begin
          errors++;
          $display("FAIL sb_a_extra: got imm=%h err=%b, required no output", imm_a, err_a);
        end else begin
          e = q_a.pop_front();
          if ({imm_a, err_a} !== {e.imm[31:0], e.err}) begin
            errors++;
            $display("FAIL sb_a: got imm=%h err=%b, required imm=%h err=%b",
                     imm_a, err_a, e.imm[31:0], e.err);
          end
        end
      end
      if (valid_b) begin
        checks++;
        if (q_b.size() == 0) begin
          errors++;
          $display("FAIL sb_b_extra: got imm=%h err=%b, required no output", imm_b, err_b);
        end else begin
          e = q_b.pop_front();
          if ({imm_b, err_b} !== {e.imm, e.err}) begin
            errors++;
            $display("FAIL sb_b: got imm=%h err=%b, required imm=%h err=%b",
                     imm_b, err_b, e.imm, e.err);
          end
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] src,
                       input logic st, input logic fl, input exp_t e);
    @(posedge clk);
    #1;
    valid_i   = v;
    instr_i   = ins;
    imm_src_i = src;
    stall_i   = st;
    flush_i   = fl;
    if (v && !st && !fl) begin
      q_a.push_back(e);
      q_b.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    valid_i = 1'b0; instr_i = '0; imm_src_i = '0; stall_i = 1'b0; flush_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({valid_a, imm_a, err_a} !== '0) begin
      errors++;
      $display("FAIL reset_a: got v=%b imm=%h err=%b, required all 0", valid_a, imm_a, err_a);
    end
    checks++;
    if ({valid_b, imm_b, err_b} !== '0) begin
      errors++;
      $display("FAIL reset_b: got v=%b imm=%h err=%b, required all 0", valid_b, imm_b, err_b);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_formats;
    drive(1, 32'hFFF00093, 3'd0, 0, 0, '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0});
    idle(1);
    // One edge after capture the 1-stage instance must already show the entry.
    checks++;
    if (valid_a !== 1'b1 || imm_a !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL latency_a: got v=%b imm=%h, required v=1 imm=ffffffff", valid_a, imm_a);
    end
    drive(1, 32'hFE000EE3, 3'd2, 0, 0, '{64'hFFFF_FFFF_FFFF_FFFC, 1'b0});
    drive(1, 32'h001000EF, 3'd3, 0, 0, '{64'h0000_0000_0000_0800, 1'b0});
    drive(1, 32'h123450B7, 3'd4, 0, 0, '{64'h0000_0000_1234_5000, 1'b0});
    drive(1, 32'h800000B7, 3'd4, 0, 0, '{64'hFFFF_FFFF_8000_0000, 1'b0});
    drive(1, 32'h8A5FF123, 3'd1, 0, 0, '{64'hFFFF_FFFF_FFFF_F8A2, 1'b0});
    idle(3);
  endtask

  task automatic test_reserved;
    drive(1, 32'hFFFFFFFF, 3'd7, 0, 0, '{64'h0, 1'b1});
    drive(1, 32'hFFFFFFFF, 3'd6, 0, 0, '{64'h0, 1'b0});
`ifdef IMM_ZICSR_EN
    drive(1, 32'h000FA073, 3'd5, 0, 0, '{64'h1F, 1'b0});
`else
    drive(1, 32'h000FA073, 3'd5, 0, 0, '{64'h0, 1'b1});
`endif
    idle(3);
  endtask

  task automatic test_back_to_back_stall;
    logic [32:0] snap_a;
    logic [64:0] snap_b;
    drive(1, 32'h00100093, 3'd0, 0, 0, model(32'h00100093, 3'd0));
    drive(1, 32'h00200093, 3'd0, 0, 0, model(32'h00200093, 3'd0));
    drive(1, 32'h00300093, 3'd0, 0, 0, model(32'h00300093, 3'd0));
    // Entries offered during the stall must not be captured.
    drive(1, 32'hDEADBEEF, 3'd0, 1, 0, '0);
    snap_a = {imm_a, err_a};
    snap_b = {imm_b, err_b};
    for (int k = 0; k < 3; k++) begin
      if (k < 2) drive(1, 32'hDEADBEEF, 3'd1, 1, 0, '0);
      else       drive(1, 32'h00400093, 3'd0, 0, 0, model(32'h00400093, 3'd0));
      checks++;
      if ({valid_a, imm_a, err_a} !== {1'b1, snap_a}) begin
        errors++;
        $display("FAIL stall_a[%0d]: got %h, required %h", k, {valid_a, imm_a, err_a},
                 {1'b1, snap_a});
      end
      checks++;
      if ({valid_b, imm_b, err_b} !== {1'b1, snap_b}) begin
        errors++;
        $display("FAIL stall_b[%0d]: got %h, required %h", k, {valid_b, imm_b, err_b},
                 {1'b1, snap_b});
      end
    end
    drive(1, 32'h00500093, 3'd0, 0, 0, model(32'h00500093, 3'd0));
    idle(3);
  endtask

  task automatic test_flush;
    drive(1, 32'h7FF00093, 3'd0, 0, 0, model(32'h7FF00093, 3'd0));
    drive(1, 32'h80000093, 3'd0, 0, 0, model(32'h80000093, 3'd0));
    drive(1, 32'h12300093, 3'd0, 0, 0, model(32'h12300093, 3'd0));
    drive(1, 32'hFFF00093, 3'd0, 1, 1, '0);
    idle(1);
    checks++;
    if ({valid_a, valid_b} !== 2'b00) begin
      errors++;
      $display("FAIL flush_now: got va=%b vb=%b, required 0 0", valid_a, valid_b);
    end
    idle(1);
    checks++;
    if ({valid_a, valid_b} !== 2'b00) begin
      errors++;
      $display("FAIL flush_empty: got va=%b vb=%b, required 0 0", valid_a, valid_b);
    end
    q_a.delete();
    q_b.delete();
    idle(1);
  endtask

  task automatic test_reset_mid;
    drive(1, 32'hFFF00093, 3'd0, 0, 0, model(32'hFFF00093, 3'd0));
    drive(1, 32'hFE000EE3, 3'd7, 0, 0, model(32'hFE000EE3, 3'd7));
    @(posedge clk);
    #2;
    valid_i = 1'b0;
    stall_i = 1'b1;
    rst_n   = 1'b0;
    #1;
    checks++;
    if ({valid_a, imm_a, err_a} !== '0) begin
      errors++;
      $display("FAIL rst_mid_a: got v=%b imm=%h err=%b, required all 0", valid_a, imm_a, err_a);
    end
    checks++;
    if ({valid_b, imm_b, err_b} !== '0) begin
      errors++;
      $display("FAIL rst_mid_b: got v=%b imm=%h err=%b, required all 0", valid_b, imm_b, err_b);
    end
    q_a.delete();
    q_b.delete();
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    stall_i = 1'b0;
    idle(1);
  endtask

  task automatic test_random;
    logic [31:0] ins;
    logic [2:0]  src;
    for (int k = 0; k < 40; k++) begin
      ins = $urandom;
      src = 3'($urandom_range(0, 7));
      drive(1'($urandom_range(0, 3) != 0), ins, src, 1'($urandom_range(0, 3) == 0), 1'b0,
            model(ins, src));
    end
    idle(4);
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d entries left, required 0/0", q_a.size(), q_b.size());
    end
  endtask

  initial begin
    test_reset();
    test_formats();
    test_reserved();
    test_back_to_back_stall();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
